// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
// Holds the arbitration mode encoding and the requester-index width helper.
package mem_arbiter_pkg;

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_nbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Rotating priority search: first set request at or after ptr, wrapping modulo p_nreqs.
// p_nreqs is a power of two, so the index addition wraps on its own.
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int p_nreqs     = 4,
  parameter int p_idx_nbits = idx_nbits(p_nreqs)
) (
  input  logic [p_nreqs-1:0]     req,
  input  logic [p_idx_nbits-1:0] ptr,
  output logic [p_idx_nbits-1:0] winner,
  output logic                   found
);

  logic [p_idx_nbits-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < p_nreqs; k++) begin
      idx = ptr + p_idx_nbits'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter sharing one single-port memory between p_nreqs requesters,
// with bounded lock bursts. Optional stall counter under MEM_ARBITER_RR_STATS_EN.
module mem_arbiter_rr
  import mem_arbiter_pkg::*;
#(
  parameter int p_nreqs      = 4,
  parameter int p_addr_nbits = 4,
  parameter int p_data_nbits = 8,
  parameter int p_max_burst  = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_nreqs-1:0]                req,
  input  logic [p_nreqs-1:0]                req_lock,
  input  logic [p_nreqs-1:0]                req_wen,
  input  logic [p_nreqs*p_addr_nbits-1:0]   req_addr,
  input  logic [p_nreqs*p_data_nbits-1:0]   req_wdata,
  output logic [p_nreqs-1:0]                grant,
  output logic [$clog2(p_nreqs)-1:0]        grant_id,
  output logic                              mem_en,
  output logic                              mem_wen,
  output logic [p_addr_nbits-1:0]           mem_addr,
  output logic [p_data_nbits-1:0]           mem_wdata
`ifdef MEM_ARBITER_RR_STATS_EN
  ,
  output logic [15:0]                       stall_count
`endif
);

  localparam int IW = idx_nbits(p_nreqs);
  localparam int BW = $clog2(p_max_burst + 1);
  localparam logic [BW-1:0] MAX_BURST = BW'(p_max_burst);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;

  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          owner_hold;
  logic [IW-1:0] win_idx;
  logic          win_valid;
  logic [BW-1:0] burst_try;

  rr_pick #(
    .p_nreqs     (p_nreqs),
    .p_idx_nbits (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .found  (pick_found)
  );

  // A locked owner that drops req loses the lock in the same cycle.
  assign owner_hold = (state_q == LOCKED) && req[owner_q];
  assign win_idx    = owner_hold ? owner_q : pick_idx;
  assign win_valid  = owner_hold || pick_found;

  // Decode the winner into a one-hot grant and mux its memory request.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    grant     = '0;
    mem_wen   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < p_nreqs; i++) begin
      if (win_valid && (win_idx == IW'(i))) begin
        grant[i]  = 1'b1;
        mem_wen   = req_wen[i];
        mem_addr  = req_addr[i*p_addr_nbits +: p_addr_nbits];
        mem_wdata = req_wdata[i*p_data_nbits +: p_data_nbits];
      end
    end
  end

  assign mem_en   = win_valid;
  assign grant_id = win_valid ? win_idx : '0;

  always_comb begin
    state_d   = FREE;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    burst_d   = '0;
    burst_try = owner_hold ? (burst_q + BW'(1)) : BW'(1);
    if (win_valid) begin
      if (req_lock[win_idx] && (burst_try < MAX_BURST)) begin
        state_d = LOCKED;
        owner_d = win_idx;
        burst_d = burst_try;
      end else begin
        ptr_d = win_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= FREE;
      ptr_q   <= '0;
      owner_q <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

`ifdef MEM_ARBITER_RR_STATS_EN
  logic        stall;
  logic [15:0] stall_q;

  // Any requester left waiting this cycle, locked burst or not.
  assign stall = |(req & ~grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (stall && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Round-robin arbiter that shares one single-port memory (register-file style, decoder-selected word enables) between p_nreqs requesters.
- Each cycle it selects one requester, forwards that requester's address, write enable and write data to the memory port, and returns a one-hot grant.
- A lock input lets the granted requester keep the port for back-to-back accesses, bounded by a burst counter.
- Sits between the requester-side ports and the memory instance.

Parameters:
- p_nreqs, 4, number of requesters; power of two, >= 2
- p_addr_nbits, 4, memory address width
- p_data_nbits, 8, memory data width
- p_max_burst, 4, max consecutive grants to one locked requester; >= 1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  p_nreqs  per-requester request
- req_lock  in  p_nreqs  per-requester "keep grant next cycle"
- req_wen  in  p_nreqs  per-requester write enable
- req_addr  in  p_nreqs*p_addr_nbits  flattened addresses; requester i at [i*p_addr_nbits +: p_addr_nbits]
- req_wdata  in  p_nreqs*p_data_nbits  flattened write data, same packing
- grant  out  p_nreqs  one-hot grant; all zeros if no request
- grant_id  out  $clog2(p_nreqs)  index of the granted requester; 0 when no grant
- mem_en  out  1  memory access valid (= |grant)
- mem_wen  out  1  req_wen of the winner, gated by mem_en
- mem_addr  out  p_addr_nbits  winner's address; 0 when idle
- mem_wdata  out  p_data_nbits  winner's write data; 0 when idle

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- State registers:
  - ptr: $clog2(p_nreqs) bits, highest-priority index
  - owner: $clog2(p_nreqs) bits
  - locked: 1 bit
  - burst_cnt: $clog2(p_max_burst+1) bits
- Reset sets ptr=0, locked=0, owner=0, burst_cnt=0.
- Outputs are combinational from state and inputs; zero latency, so an access is issued in the same cycle as the grant.
- During reset, outputs still follow the combinational rules. With req=0, all outputs are 0.
- Mode FREE (locked=0):
  - Winner = first i with req[i]=1, searching ptr, ptr+1, ... modulo p_nreqs (wrap-around).
- Mode LOCKED (locked=1):
  - If req[owner]=1, the winner is owner regardless of other requests.
  - If req[owner]=0, the lock is released immediately and this cycle arbitrates as FREE.
- State update at the rising edge, when a winner w exists:
  - If req_lock[w]=1 and the burst count (burst_cnt+1 for a continuing owner, or 1 for a new owner) < p_max_burst: locked<=1, owner<=w, burst_cnt<=that count, ptr unchanged.
  - Otherwise: locked<=0, burst_cnt<=0, ptr<=(w+1) mod p_nreqs.
- With no winner: locked<=0, burst_cnt<=0, ptr unchanged.
- p_max_burst=1 disables locking in effect; every grant rotates the pointer.
- A single requester holding req continuously is granted every cycle; there is no forced idle gap.
- Simultaneous requests from all requesters: in FREE mode each is served once per p_nreqs cycles.
- grant is always one-hot or zero. mem_* fields are never X when inputs are known.

Optional Feature:
- Macro: MEM_ARBITER_RR_STATS_EN
- When defined:
  - Adds output stall_count (16 bits): cycles in which at least one requester had req=1 but was not granted.
  - Saturates at 16'hFFFF; reset to 0.
  - Counts even during a locked burst.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_arbiter_pkg:
  - typedef for the arbiter state {FREE, LOCKED}
  - localparam helper for the index width
- Natural sub-module: rr_pick, a combinational rotating priority search (req, ptr) -> winner index + found flag.
- The existing Decoder_RTL converts grant_id to grant (one-hot), gated by found.

Test Plan:
- Reset, then req=0 -> grant=0, mem_en=0, mem_addr=0; ptr remains 0.
- p_nreqs=4, req=4'b1111, lock=0, held 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3; mem_addr follows each requester's address.
- ptr=2 (after granting 1), req=4'b0011 -> grant=4'b0001 (wrap-around); next cycle with same req -> grant=4'b0010.
- req=4'b0101, req_lock[0]=1 held, p_max_burst=4 -> requester 0 granted 4 consecutive cycles, then grant=4'b0100.
- Locked owner 0 drops req mid-burst while req[3]=1 -> requester 3 granted the same cycle; locked clears.
- Requester 2 writes (wen=1, addr=4'h5, wdata=8'hA7) -> mem_en=1, mem_wen=1, mem_addr=5, mem_wdata=A7. With the stats feature on and req=4'b0110 for 3 cycles -> stall_count=3.
